// File: rtl/trig_pkg.sv
// Shared definitions for the trig sequencer: state encoding, widths, defaults.
package trig_pkg;

    localparam int unsigned FLOAT_W            = 32;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_NORM   = 3'd2,
        ST_CORDIC = 3'd3,
        ST_CONV   = 3'd4,
        ST_RESULT = 3'd5
    } seq_state_t;

endpackage

// File: rtl/trig_sequencer_done_edge.sv
// Rising-edge detector for a stage done level.
// A level still high from the previous operation is never reported as a new
// edge: after clr the detector waits until done has been seen low once.
module done_edge (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic done,
    output logic rise_c
);

    logic done_q;
    logic armed_q;

    // Registered previous level plus an arm bit that is set once done is seen low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q  <= 1'b0;
            armed_q <= 1'b0;
        end else if (clr) begin
            done_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            done_q  <= done;
            armed_q <= armed_q | ~done;
        end
    end

    assign rise_c = done & ~done_q & armed_q;

endmodule

// File: rtl/trig_sequencer.sv
// Trig datapath sequencer: normalizer -> CORDIC -> converter, valid/ack result.
// Optional per-stage watchdog is built when SEQ_TIMEOUT_EN is defined.
module trig_sequencer
    import trig_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned CNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [FLOAT_W-1:0] req_angle,
    output logic               req_ready,
    output logic               res_valid,
    output logic [FLOAT_W-1:0] res_sin,
    output logic [FLOAT_W-1:0] res_cos,
    output logic               res_err,
    input  logic               res_ack,
    output logic               busy,
    output logic               dp_rst,
    output logic               norm_valid,
    output logic [FLOAT_W-1:0] norm_angle,
    input  logic               norm_ready,
    input  logic               norm_done,
    output logic               cordic_start,
    input  logic               cordic_done,
    output logic               conv_start,
    input  logic               conv_done,
    input  logic [FLOAT_W-1:0] conv_sin,
    input  logic [FLOAT_W-1:0] conv_cos
);

    if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cfg_check
        $error("trig_sequencer: CNT_W too small for TIMEOUT_CYCLES");
    end

    seq_state_t         state_q, state_d;
    logic               norm_issued_q, norm_issued_d;
    logic               req_ready_d, res_valid_d, busy_d, dp_rst_d;
    logic               norm_valid_d, cordic_start_d, conv_start_d;
    logic [FLOAT_W-1:0] angle_d, sin_d, cos_d;
    logic               stage_clr;
    logic               norm_rise_c, cordic_rise_c, conv_rise_c;

    assign stage_clr = (state_q == ST_CLEAR);

    done_edge u_norm_edge (
        .clk    (clk),
        .rst    (rst),
        .clr    (stage_clr),
        .done   (norm_done),
        .rise_c (norm_rise_c)
    );

    done_edge u_cordic_edge (
        .clk    (clk),
        .rst    (rst),
        .clr    (stage_clr),
        .done   (cordic_done),
        .rise_c (cordic_rise_c)
    );

    done_edge u_conv_edge (
        .clk    (clk),
        .rst    (rst),
        .clr    (stage_clr),
        .done   (conv_done),
        .rise_c (conv_rise_c)
    );

`ifdef SEQ_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             res_err_q, res_err_d;
    logic             stage_active;

    assign stage_active = (state_q == ST_NORM) || (state_q == ST_CORDIC) ||
                          (state_q == ST_CONV);
    assign res_err      = res_err_q;
`else
    assign res_err = 1'b0;
`endif

    // Next-state and next-output logic; start pulses default low.
    always_comb begin
        state_d        = state_q;
        norm_issued_d  = norm_issued_q;
        req_ready_d    = req_ready;
        res_valid_d    = res_valid;
        dp_rst_d       = 1'b0;
        norm_valid_d   = 1'b0;
        cordic_start_d = 1'b0;
        conv_start_d   = 1'b0;
        angle_d        = norm_angle;
        sin_d          = res_sin;
        cos_d          = res_cos;
`ifdef SEQ_TIMEOUT_EN
        cnt_d          = '0;
        res_err_d      = res_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    angle_d     = req_angle;
                    req_ready_d = 1'b0;
                    dp_rst_d    = 1'b1;
                    state_d     = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                // Issue the normalizer start on NORM entry if it is already idle.
                norm_valid_d  = norm_ready;
                norm_issued_d = norm_ready;
                state_d       = ST_NORM;
            end
            ST_NORM: begin
                if (!norm_issued_q) begin
                    if (norm_ready) begin
                        norm_valid_d  = 1'b1;
                        norm_issued_d = 1'b1;
                    end
                end else if (norm_rise_c) begin
                    cordic_start_d = 1'b1;
                    state_d        = ST_CORDIC;
                end
            end
            ST_CORDIC: begin
                if (cordic_rise_c) begin
                    conv_start_d = 1'b1;
                    state_d      = ST_CONV;
                end
            end
            ST_CONV: begin
                if (conv_rise_c) begin
                    sin_d       = conv_sin;
                    cos_d       = conv_cos;
                    res_valid_d = 1'b1;
                    state_d     = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (res_ack) begin
                    res_valid_d = 1'b0;
                    req_ready_d = 1'b1;
`ifdef SEQ_TIMEOUT_EN
                    res_err_d   = 1'b0;
`endif
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                req_ready_d = 1'b1;
                res_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

`ifdef SEQ_TIMEOUT_EN
        // Watchdog: counts cycles spent in the current stage, aborts on limit.
        if (stage_active && (state_d == state_q)) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                norm_valid_d = 1'b0;
                sin_d        = '0;
                cos_d        = '0;
                res_err_d    = 1'b1;
                res_valid_d  = 1'b1;
                state_d      = ST_RESULT;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`endif

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            norm_issued_q <= 1'b0;
            req_ready     <= 1'b1;
            res_valid     <= 1'b0;
            res_sin       <= '0;
            res_cos       <= '0;
            busy          <= 1'b0;
            dp_rst        <= 1'b0;
            norm_valid    <= 1'b0;
            norm_angle    <= '0;
            cordic_start  <= 1'b0;
            conv_start    <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            cnt_q         <= '0;
            res_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            norm_issued_q <= norm_issued_d;
            req_ready     <= req_ready_d;
            res_valid     <= res_valid_d;
            res_sin       <= sin_d;
            res_cos       <= cos_d;
            busy          <= busy_d;
            dp_rst        <= dp_rst_d;
            norm_valid    <= norm_valid_d;
            norm_angle    <= angle_d;
            cordic_start  <= cordic_start_d;
            conv_start    <= conv_start_d;
`ifdef SEQ_TIMEOUT_EN
            cnt_q         <= cnt_d;
            res_err_q     <= res_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_trig_sequencer.sv
// Directed bench for trig_sequencer with behavioural stage stubs.
// Define SEQ_TIMEOUT_EN to build the watchdog variant (TIMEOUT_CYCLES=16).
module tb_trig_sequencer;

    localparam int TN = 3;
    localparam int TV = 2;
`ifdef SEQ_TIMEOUT_EN
    localparam int TC = 10;
    localparam int unsigned TO = 16;
`else
    localparam int TC = 20;
    localparam int unsigned TO = 1024;
`endif
    localparam int LAT = 4 + TN + TC + TV;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, res_valid, res_err, res_ack, busy, dp_rst;
    logic [31:0] req_angle, res_sin, res_cos, norm_angle, conv_sin, conv_cos;
    logic        norm_valid, norm_ready, norm_done, cordic_start, cordic_done;
    logic        conv_start, conv_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    trig_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
        .res_valid(res_valid), .res_sin(res_sin), .res_cos(res_cos),
        .res_err(res_err), .res_ack(res_ack), .busy(busy), .dp_rst(dp_rst),
        .norm_valid(norm_valid), .norm_angle(norm_angle), .norm_ready(norm_ready),
        .norm_done(norm_done), .cordic_start(cordic_start), .cordic_done(cordic_done),
        .conv_start(conv_start), .conv_done(conv_done),
        .conv_sin(conv_sin), .conv_cos(conv_cos)
    );

    // Stage stubs: done rises st_dly cycles after the start pulse.
    logic [2:0] st_start, st_done;
    int         st_tmr [3];
    int         st_dly [3];
    bit         st_stick [3];
    bit         st_dead [3];

    assign st_start    = {conv_start, cordic_start, norm_valid};
    assign norm_done   = st_done[0];
    assign cordic_done = st_done[1];
    assign conv_done   = st_done[2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            st_done <= '0;
            for (int i = 0; i < 3; i++) st_tmr[i] <= 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (st_start[i]) begin
                    st_done[i] <= 1'b0;
                    st_tmr[i]  <= st_dly[i] - 1;
                end else if (dp_rst && !st_stick[i]) begin
                    st_done[i] <= 1'b0;
                    st_tmr[i]  <= 0;
                end else if (st_tmr[i] == 1) begin
                    st_done[i] <= !st_dead[i];
                    st_tmr[i]  <= 0;
                end else if (st_tmr[i] > 1) begin
                    st_tmr[i]  <= st_tmr[i] - 1;
                end
            end
        end
    end

    // Cycle counter and pulse monitors.
    int   cyc = 0, n_dp = 0, n_nv = 0, n_cs = 0, n_vs = 0, n_rv = 0, cordic_at = 0;
    logic res_valid_q = 1'b0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dp_rst)       n_dp <= n_dp + 1;
        if (norm_valid)   n_nv <= n_nv + 1;
        if (cordic_start) begin
            n_cs      <= n_cs + 1;
            cordic_at <= cyc;
        end
        if (conv_start)   n_vs <= n_vs + 1;
        res_valid_q <= res_valid;
        if (res_valid && !res_valid_q) n_rv <= n_rv + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Present a request for one cycle; c0 is the cycle count just after accept.
    task automatic do_req(input logic [31:0] a, output int c0);
        @(negedge clk);
        req_valid = 1'b1;
        req_angle = a;
        @(negedge clk);
        req_valid = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_result(input int c0, output int lat);
        int n;
        n = 0;
        while (!res_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) check_eq("res_valid_timeout", 32'(res_valid), 32'd1);
        lat = cyc - c0;
    endtask

    task automatic ack_result(input string tag);
        @(negedge clk);
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        check_eq(tag, {29'd0, res_valid, req_ready, busy}, 32'b010);
    endtask

    int c0, lat, d_dp, d_nv, d_cs, d_vs, rv0;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_angle = '0; res_ack = 1'b0;
        norm_ready = 1'b1; conv_sin = '0; conv_cos = '0;
        st_dly[0] = TN; st_dly[1] = TC; st_dly[2] = TV;
        for (int i = 0; i < 3; i++) begin st_stick[i] = 1'b0; st_dead[i] = 1'b0; end
        repeat (3) @(negedge clk);
        check_eq("rst_ctrl", {24'd0, req_ready, res_valid, res_err, busy, dp_rst,
                              norm_valid, cordic_start, conv_start}, 32'h80);
        check_eq("rst_data", res_sin | res_cos | norm_angle, 32'h0);
        rst = 1'b0;

        // 1: basic 30 degree operation
        conv_sin = 32'h3F000000; conv_cos = 32'h3F5DB3D7;
        d_dp = n_dp; d_nv = n_nv; d_cs = n_cs; d_vs = n_vs;
        do_req(32'h41F00000, c0);
        check_eq("t1_clear", {29'd0, dp_rst, busy, req_ready}, 32'b110);
        check_eq("t1_angle", norm_angle, 32'h41F00000);
        wait_result(c0, lat);
        check_eq("t1_latency", 32'(lat), 32'(LAT));
        check_eq("t1_sin", res_sin, 32'h3F000000);
        check_eq("t1_cos", res_cos, 32'h3F5DB3D7);
        check_eq("t1_err", 32'(res_err), 32'd0);
        check_eq("t1_pulses", {n_dp - d_dp, n_nv - d_nv, n_cs - d_cs, n_vs - d_vs} == {4{32'd1}} ?
                 32'd1 : 32'd0, 32'd1);
        ack_result("t1_ack");

        // 2: norm_done left high from the previous op must not complete NORM
        st_stick[0] = 1'b1;
        conv_sin = 32'h3F800000; conv_cos = 32'h00000000;
        do_req(32'h42B40000, c0);
        wait_result(c0, lat);
        check_eq("t2_cordic_at", 32'(cordic_at - c0), 32'(TN + 2));
        check_eq("t2_latency", 32'(lat), 32'(LAT));
        check_eq("t2_sin", res_sin, 32'h3F800000);
        ack_result("t2_ack");
        st_stick[0] = 1'b0;

        // 3: normalizer busy for the first NORM cycles; ack held high throughout
        norm_ready = 1'b0; res_ack = 1'b1;
        conv_sin = 32'h3F3504F3; conv_cos = 32'h3F3504F3;
        do_req(32'h42340000, c0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("t3_nv_wait", 32'(norm_valid), 32'd0);
        end
        norm_ready = 1'b1;
        @(negedge clk);
        check_eq("t3_nv_fire", 32'(norm_valid), 32'd1);
        wait_result(c0, lat);
        check_eq("t3_latency", 32'(lat), 32'(LAT + 6));
        @(negedge clk);
        check_eq("t3_same_cycle_ack", {30'd0, res_valid, req_ready}, 32'b01);
        res_ack = 1'b0;

        // 4: request held during RESULT is ignored until IDLE
        conv_sin = 32'hBF000000; conv_cos = 32'h3F000000;
        do_req(32'h42340000, c0);
        wait_result(c0, lat);
        check_eq("t4_latency", 32'(lat), 32'(LAT));
        req_valid = 1'b1; req_angle = 32'h43340000;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check_eq("t4_hold_ctrl", {29'd0, res_valid, req_ready, busy}, 32'b101);
            check_eq("t4_hold_sin", res_sin ^ norm_angle, 32'hBF000000 ^ 32'h42340000);
        end
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        check_eq("t4_idle", {30'd0, req_ready, busy}, 32'b10);
        @(negedge clk);
        req_valid = 1'b0;
        c0 = cyc;
        check_eq("t4_reaccept", {30'd0, req_ready, busy}, 32'b01);
        check_eq("t4_new_angle", norm_angle, 32'h43340000);
        wait_result(c0, lat);
        check_eq("t4_latency2", 32'(lat), 32'(LAT));
        ack_result("t4_ack");

        // 5: asynchronous reset during CORDIC
        do_req(32'h41F00000, c0);
        repeat (8) @(negedge clk);
        check_eq("t5_busy", 32'(busy), 32'd1);
        rv0 = n_rv;
        #2 rst = 1'b1;
        #1;
        check_eq("t5_rst_ctrl", {24'd0, req_ready, res_valid, res_err, busy, dp_rst,
                                 norm_valid, cordic_start, conv_start}, 32'h80);
        check_eq("t5_rst_data", res_sin | res_cos | norm_angle, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check_eq("t5_no_result", 32'(n_rv - rv0), 32'd0);
        check_eq("t5_idle", {30'd0, req_ready, busy}, 32'b10);
        conv_sin = 32'h3F000000; conv_cos = 32'h3F5DB3D7;
        do_req(32'h41F00000, c0);
        wait_result(c0, lat);
        check_eq("t5_recover_lat", 32'(lat), 32'(LAT));
        check_eq("t5_recover_sin", res_sin, 32'h3F000000);
        ack_result("t5_ack");

`ifdef SEQ_TIMEOUT_EN
        // 6: CORDIC never finishes; watchdog aborts 16 cycles after CORDIC entry
        st_dead[1] = 1'b1;
        do_req(32'h41F00000, c0);
        wait_result(c0, lat);
        check_eq("t6_latency", 32'(lat), 32'(TN + 2 + 16));
        check_eq("t6_err", 32'(res_err), 32'd1);
        check_eq("t6_zero", res_sin | res_cos, 32'h0);
        ack_result("t6_ack");
        check_eq("t6_err_clr", 32'(res_err), 32'd0);
        st_dead[1] = 1'b0;
        conv_sin = 32'h3F800000; conv_cos = 32'h00000000;
        do_req(32'h42B40000, c0);
        wait_result(c0, lat);
        check_eq("t6_next_lat", 32'(lat), 32'(LAT));
        check_eq("t6_next_sin", res_sin, 32'h3F800000);
        check_eq("t6_next_err", 32'(res_err), 32'd0);
        ack_result("t6_next_ack");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
